// File: rtl/sd_emmc_cmd_phy.sv
// sd_emmc_cmd_phy
// Per-card CMD-line serializer/deserializer for one eMMC device.
// Sends a 48-bit command frame {cmd, crc7, end bit} MSB first, then
// optionally captures a 48-bit (R1/R1b/R3) or 136-bit (R2) response. It
// reports the response, the CRC and index checks and a one-cycle finish pulse.
//
// Ports:
//   sd_clk        card clock, all logic on the rising edge
//   rst           asynchronous, active-high reset
//   start_i       1-cycle strobe: send cmd_i (honoured only when idle)
//   go_idle_i     abort the current transaction, no finish pulse
//   setting_i     {long_response, expect_response}, latched at start
//   cmd_i         {2'b01, index[5:0], argument[31:0]}
//   cmd_dat_i     CMD line input, sampled on the rising edge
//   cmd_out_o     CMD line output value (1 when not driving)
//   cmd_oe_o      CMD output enable, 1 while the command frame is driven
//   response_o    captured response, left-justified (120 bits)
//   crc_ok_o      response CRC7 and end bit were good
//   index_ok_o    response index matched the command index
//   finish_o      1-cycle pulse when the transaction completes
//   inhibit_cmd_o high while a transaction is in progress
module sd_emmc_cmd_phy #(
    parameter int NCR_MAX    = 64,
    parameter int NCC_CYCLES = 8
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         go_idle_i,
    input  logic [1:0]   setting_i,
    input  logic [39:0]  cmd_i,
    input  logic         cmd_dat_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    output logic [119:0] response_o,
    output logic         crc_ok_o,
    output logic         index_ok_o,
    output logic         finish_o,
    output logic         inhibit_cmd_o
);

    localparam int CNT_MAX_A = (NCR_MAX > 136) ? NCR_MAX : 136;
    localparam int CNT_MAX   = (NCC_CYCLES > CNT_MAX_A) ? NCC_CYCLES : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_RSP,
        READ,
        NCC,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [47:0]        tx_sr;
    logic [127:0]       rx_sr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   rsp_len;
    logic [6:0]         crc_rx;
    logic               crc_window;
    logic               long_rsp;
    logic               expect_rsp;
    logic [5:0]         cmd_index;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_bits(input logic [39:0] data);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, data[i]);
        end
        return c;
    endfunction

    // In READ, cnt is the number of response bits already received, so the
    // bit arriving now is number cnt+1 counted from the start bit. Short
    // responses protect bits 47:8 (the leading start bit leaves a zero CRC
    // unchanged); R2 protects only bits 127:8, skipping the first 8 bits.
    assign rsp_len    = long_rsp ? CNT_W'(136) : CNT_W'(48);
    assign crc_window = long_rsp ? ((cnt >= CNT_W'(8)) && (cnt <= CNT_W'(127)))
                                 : (cnt <= CNT_W'(39));

    // Outputs decode straight from the state register, so an asynchronous
    // reset releases the CMD line immediately.
    assign cmd_oe_o      = (state == WRITE);
    assign cmd_out_o     = (state == WRITE) ? tx_sr[47] : 1'b1;
    assign finish_o      = (state == FINISH);
    assign inhibit_cmd_o = (state != IDLE);

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start_i) state_next = WRITE;
            WRITE:    if (cnt == CNT_W'(47)) state_next = expect_rsp ? WAIT_RSP : NCC;
            NCC:      if (cnt == CNT_W'(NCC_CYCLES - 1)) state_next = FINISH;
            WAIT_RSP: begin
                if (!cmd_dat_i) begin
                    state_next = READ;
                end else if (cnt == CNT_W'(NCR_MAX - 1)) begin
                    state_next = FINISH;
                end
            end
            READ:     if (cnt == rsp_len) state_next = FINISH;
            FINISH:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (go_idle_i) begin
            state_next = IDLE;
        end
    end

    // Datapath. An abort freezes everything so the held response survives.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            tx_sr      <= '0;
            rx_sr      <= '0;
            cnt        <= '0;
            crc_rx     <= '0;
            long_rsp   <= 1'b0;
            expect_rsp <= 1'b0;
            cmd_index  <= '0;
            response_o <= '0;
            crc_ok_o   <= 1'b0;
            index_ok_o <= 1'b0;
        end else if (!go_idle_i) begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        tx_sr      <= {cmd_i, crc7_bits(cmd_i), 1'b1};
                        cnt        <= '0;
                        long_rsp   <= setting_i[1];
                        expect_rsp <= setting_i[0];
                        cmd_index  <= cmd_i[37:32];
                        crc_ok_o   <= 1'b0;
                        index_ok_o <= 1'b0;
                    end
                end
                WRITE: begin
                    tx_sr <= {tx_sr[46:0], 1'b1};
                    if (cnt == CNT_W'(47)) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NCC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NCC_CYCLES - 1)) begin
                        crc_ok_o   <= 1'b1;
                        index_ok_o <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (!cmd_dat_i) begin
                        cnt    <= CNT_W'(1);
                        rx_sr  <= '0;
                        crc_rx <= '0;
                    end else if (cnt == CNT_W'(NCR_MAX - 1)) begin
                        response_o <= '0;
                        crc_ok_o   <= 1'b0;
                        index_ok_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    if (cnt != rsp_len) begin
                        rx_sr <= {rx_sr[126:0], cmd_dat_i};
                        cnt   <= cnt + 1'b1;
                        if (crc_window) begin
                            crc_rx <= crc7_step(crc_rx, cmd_dat_i);
                        end
                    end else if (long_rsp) begin
                        response_o <= rx_sr[127:8];
                        crc_ok_o   <= (crc_rx == rx_sr[7:1]) && rx_sr[0];
                        index_ok_o <= 1'b1;
                    end else begin
                        response_o <= {rx_sr[39:8], 88'b0};
                        crc_ok_o   <= (crc_rx == rx_sr[7:1]) && rx_sr[0];
                        index_ok_o <= (rx_sr[45:40] == cmd_index);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_emmc_cmd_phy.sv
// tb_sd_emmc_cmd_phy
// Directed bench for sd_emmc_cmd_phy. Each transaction is described by its
// command, setting, card response and response delay. From these the bench
// derives a cycle-by-cycle timeline of expected outputs. A negedge process
// compares the DUT against that timeline every cycle.
module tb_sd_emmc_cmd_phy;

    localparam int NCR_MAX    = 64;
    localparam int NCC_CYCLES = 8;

    logic         sd_clk;
    logic         rst;
    logic         start_i;
    logic         go_idle_i;
    logic [1:0]   setting_i;
    logic [39:0]  cmd_i;
    logic         cmd_dat_i;
    logic         cmd_out_o;
    logic         cmd_oe_o;
    logic [119:0] response_o;
    logic         crc_ok_o;
    logic         index_ok_o;
    logic         finish_o;
    logic         inhibit_cmd_o;

    typedef struct {
        logic         oe;
        logic         out;
        logic         inh;
        logic         fin;
        int           chk;
        logic [119:0] resp;
        logic         crc;
        logic         idx;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur;
    logic [119:0] last_resp;
    logic         last_crc;
    logic         last_idx;
    logic [119:0] model_resp;
    logic [47:0]  cap;
    bit           cmp_en;
    int           checks;
    int           errors;

    sd_emmc_cmd_phy #(
        .NCR_MAX    (NCR_MAX),
        .NCC_CYCLES (NCC_CYCLES)
    ) dut (
        .sd_clk        (sd_clk),
        .rst           (rst),
        .start_i       (start_i),
        .go_idle_i     (go_idle_i),
        .setting_i     (setting_i),
        .cmd_i         (cmd_i),
        .cmd_dat_i     (cmd_dat_i),
        .cmd_out_o     (cmd_out_o),
        .cmd_oe_o      (cmd_oe_o),
        .response_o    (response_o),
        .crc_ok_o      (crc_ok_o),
        .index_ok_o    (index_ok_o),
        .finish_o      (finish_o),
        .inhibit_cmd_o (inhibit_cmd_o)
    );

    initial begin
        sd_clk = 1'b0;
        forever #5 sd_clk = ~sd_clk;
    end

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_model(input logic [135:0] msg, input int nbits);
        logic [142:0] r;
        r = {msg, 7'b0};
        for (int i = nbits + 6; i >= 7; i--) begin
            if (r[i]) begin
                r[i-7 +: 8] = r[i-7 +: 8] ^ 8'h89;
            end
        end
        return r[6:0];
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
        end
    endtask

    // Compare process: one timeline entry per cycle; an empty timeline means
    // idle with the most recently settled results held.
    always @(negedge sd_clk) begin
        if (cmp_en) begin
            if (exp_q.size() > 0) begin
                cur       = exp_q.pop_front();
                last_resp = cur.resp;
                last_crc  = cur.crc;
                last_idx  = cur.idx;
            end else begin
                cur.oe   = 1'b0;
                cur.out  = 1'b1;
                cur.inh  = 1'b0;
                cur.fin  = 1'b0;
                cur.chk  = 1;
                cur.resp = last_resp;
                cur.crc  = last_crc;
                cur.idx  = last_idx;
            end
            checkOutput("ctrl", 128'({cmd_oe_o, cmd_out_o, inhibit_cmd_o, finish_o}),
                        128'({cur.oe, cur.out, cur.inh, cur.fin}));
            if (cur.chk == 1) begin
                checkOutput("result", 128'({response_o, crc_ok_o, index_ok_o}),
                            128'({cur.resp, cur.crc, cur.idx}));
            end else if (cur.chk == 2) begin
                checkOutput("cleared", 128'({crc_ok_o, index_ok_o}), 128'(2'b00));
            end
            if (cmd_oe_o) begin
                cap = {cap[46:0], cmd_out_o};
            end
        end
    end

    // abort_kind: 0 none, 1 go_idle_i sampled at edge abort_at, 2 rst raised
    // during cycle abort_at. delay: edges after WAIT_RSP entry until the start
    // bit is sampled (0 = silent card). extra_start_at: stray start_i edge.
    task automatic applyStimulus(input logic [39:0] cmd, input logic [1:0] setting,
                                 input logic [135:0] rsp, input int delay,
                                 input int abort_kind, input int abort_at,
                                 input int extra_start_at);
        logic [47:0]  frame;
        logic [119:0] res_resp;
        logic         res_crc;
        logic         res_idx;
        int           total;
        int           fin_cyc;
        int           len;
        int           run_len;
        int           n;
        exp_t         e;

        frame = {cmd, crc7_model(136'(cmd), 40), 1'b1};
        total = setting[1] ? 136 : 48;
        if (!setting[0]) begin
            fin_cyc  = 48 + NCC_CYCLES;
            res_resp = model_resp;
            res_crc  = 1'b1;
            res_idx  = 1'b1;
        end else if (delay == 0) begin
            fin_cyc  = 48 + NCR_MAX;
            res_resp = '0;
            res_crc  = 1'b0;
            res_idx  = 1'b0;
        end else if (setting[1]) begin
            fin_cyc  = 48 + delay + total;
            res_resp = rsp[127:8];
            res_crc  = (crc7_model(136'(rsp[127:8]), 120) == rsp[7:1]) && rsp[0];
            res_idx  = 1'b1;
        end else begin
            fin_cyc  = 48 + delay + total;
            res_resp = {rsp[39:8], 88'b0};
            res_crc  = (crc7_model(136'(rsp[47:8]), 40) == rsp[7:1]) && rsp[0];
            res_idx  = (rsp[45:40] == cmd[37:32]);
        end
        len     = (abort_kind != 0) ? abort_at : fin_cyc + 1;
        run_len = (abort_kind != 0) ? abort_at + 1 : fin_cyc + 1;

        @(posedge sd_clk);
        #1;
        cmd_i     = cmd;
        setting_i = setting;
        start_i   = 1'b1;
        @(posedge sd_clk);
        #1;
        start_i = 1'b0;

        for (int k = 0; k < len; k++) begin
            e.oe  = (k < 48);
            e.out = (k < 48) ? frame[47-k] : 1'b1;
            e.inh = 1'b1;
            e.fin = (k == fin_cyc);
            if (k == fin_cyc) begin
                e.chk  = 1;
                e.resp = res_resp;
                e.crc  = res_crc;
                e.idx  = res_idx;
            end else begin
                e.chk  = (k == 0) ? 2 : 0;
                e.resp = model_resp;
                e.crc  = 1'b0;
                e.idx  = 1'b0;
            end
            exp_q.push_back(e);
        end
        if (abort_kind == 2) begin
            e.oe   = 1'b0;
            e.out  = 1'b1;
            e.inh  = 1'b0;
            e.fin  = 1'b0;
            e.chk  = 1;
            e.resp = '0;
            e.crc  = 1'b0;
            e.idx  = 1'b0;
            exp_q.push_back(e);
        end

        for (int k = 0; k < run_len; k++) begin
            n         = k + 1 - (48 + delay) + 1;
            cmd_dat_i = (setting[0] && delay > 0 && n >= 1 && n <= total) ? rsp[total - n] : 1'b1;
            go_idle_i = (abort_kind == 1 && k + 1 == abort_at);
            start_i   = (extra_start_at > 0 && k + 1 == extra_start_at);
            if (abort_kind == 2 && k == abort_at) begin
                #1;
                rst = 1'b1;
                #1;
                checkOutput("async_rst", 128'({cmd_oe_o, cmd_out_o, inhibit_cmd_o}), 128'(3'b010));
                break;
            end
            @(posedge sd_clk);
            #1;
        end
        cmd_dat_i = 1'b1;
        go_idle_i = 1'b0;
        start_i   = 1'b0;
        if (abort_kind == 2) begin
            @(posedge sd_clk);
            @(posedge sd_clk);
            #1;
            rst = 1'b0;
        end

        if (abort_kind == 2) begin
            model_resp = '0;
        end else if (abort_kind == 0) begin
            model_resp = res_resp;
        end
    endtask

    logic [135:0] r_ok;
    logic [135:0] r_badidx;
    logic [135:0] r_endbad;
    logic [119:0] cid;
    logic [135:0] r2;
    logic [135:0] r2_bad;

    initial begin
        checks     = 0;
        errors     = 0;
        cmp_en     = 1'b0;
        last_resp  = '0;
        last_crc   = 1'b0;
        last_idx   = 1'b0;
        model_resp = '0;
        cap        = '0;
        rst        = 1'b1;
        start_i    = 1'b0;
        go_idle_i  = 1'b0;
        setting_i  = 2'b00;
        cmd_i      = '0;
        cmd_dat_i  = 1'b1;

        r_ok     = 136'h11_0000_0900_67;
        r_badidx = 136'h12_0000_0900_67;
        r_endbad = 136'h11_0000_0900_66;
        cid      = 120'h03_5344_5355_3136_4780_1234_5678_0131;
        r2       = {8'h3F, cid, crc7_model(136'(cid), 120), 1'b1};
        r2_bad   = r2 ^ (136'd1 << 50);

        repeat (3) @(posedge sd_clk);
        #1;
        checkOutput("reset_ctrl", 128'({cmd_oe_o, cmd_out_o, inhibit_cmd_o, finish_o}), 128'(4'b0100));
        checkOutput("reset_result", 128'({response_o, crc_ok_o, index_ok_o}), 128'(0));
        rst    = 1'b0;
        cmp_en = 1'b1;

        checkOutput("crc_cmd0", 128'(crc7_model(136'h40_0000_0000, 40)), 128'(7'h4A));
        checkOutput("crc_cmd17", 128'(crc7_model(136'h51_0000_0000, 40)), 128'(7'h2A));
        checkOutput("crc_r1", 128'(crc7_model(136'h11_0000_0900, 40)), 128'(7'h33));

        applyStimulus(40'h40_0000_0000, 2'b00, '0, 0, 0, 0, 0);
        checkOutput("cmd0_frame", 128'(cap), 128'(48'h40_0000_0000_95));
        checkOutput("cmd0_crc_ok", 128'(crc_ok_o), 128'(1));

        applyStimulus(40'h51_0000_0000, 2'b01, r_ok, 5, 0, 0, 30);
        checkOutput("cmd17_frame", 128'(cap), 128'(48'h51_0000_0000_55));
        checkOutput("cmd17_rsp", 128'({response_o[119:88], crc_ok_o, index_ok_o}),
                    128'({32'h0000_0900, 1'b1, 1'b1}));

        applyStimulus(40'h51_0000_0000, 2'b01, r_badidx, 5, 0, 0, 0);
        checkOutput("badidx_flags", 128'({crc_ok_o, index_ok_o}), 128'(2'b00));

        applyStimulus(40'h42_0000_0000, 2'b11, r2, 3, 0, 0, 0);
        checkOutput("r2_rsp", 128'({response_o, crc_ok_o}), 128'({cid, 1'b1}));
        applyStimulus(40'h42_0000_0000, 2'b11, r2_bad, 3, 0, 0, 0);

        applyStimulus(40'h51_0000_0000, 2'b01, '0, 0, 0, 0, 0);

        applyStimulus(40'h51_0000_0000, 2'b01, r_ok, 5, 1, 20, 0);

        @(posedge sd_clk);
        #1;
        start_i   = 1'b1;
        go_idle_i = 1'b1;
        @(posedge sd_clk);
        #1;
        start_i   = 1'b0;
        go_idle_i = 1'b0;
        repeat (3) @(posedge sd_clk);
        #1;

        applyStimulus(40'h51_0000_0000, 2'b01, r_ok, 5, 2, 70, 0);
        applyStimulus(40'h51_0000_0000, 2'b01, r_ok, 5, 2, 10, 0);
        applyStimulus(40'h51_0000_0000, 2'b01, r_ok, 4, 0, 0, 0);
        applyStimulus(40'h51_0000_0000, 2'b01, r_endbad, 2, 0, 0, 0);

        repeat (4) @(posedge sd_clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL timeline_drain: got %0d entries left, expected 0", exp_q.size());
        end
        checks++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
